div_rs_sched: RTL and testbench
===============================

Name: div_rs_sched

Overview:
- Four-entry reservation station and issue scheduler for the iterative integer divide unit (signed DIV / unsigned REMU).
- Accepts dispatched divide ops and captures their operands from the CDB.
- Issues the oldest fully-ready entry to the divider using its valid_in/ready handshake.
- Arbitrates the divider result onto the CDB, and on a pipeline flush discards both queued ops and the op in flight.

Parameters:
- DEPTH, 4: number of RS entries (power of 2, at least 2).
- ROB_W, 4: ROB tag width.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset; one clock, reset is asynchronous and active-low
- alloc_valid  in  1  dispatch request
- alloc_ready  out  1  at least one free entry
- alloc_rob  in  ROB_W  destination ROB tag
- alloc_aluop  in  4  op; bit0=1 signed divide, bit0=0 unsigned remainder
- alloc_s1_rdy / alloc_s2_rdy  in  1  operand already valid
- alloc_s1_tag / alloc_s2_tag  in  ROB_W  producer tag when not ready
- alloc_s1_val / alloc_s2_val  in  32  operand value when ready (s1=dividend, s2=divisor)
- cdb_valid  in  1  CDB broadcast valid
- cdb_in  in  CDB_packet_t  broadcast (dest_ROB_entry, result)
- flush  in  1  mispredict squash
- div_valid_in  out  1  issue strobe to divider
- div_ready  in  1  divider idle
- div_rob  out  ROB_W  issued tag
- div_aluop  out  4  issued op
- div_dividend / div_divisor  out  32  issued operands
- div_valid_out  in  1  divider result pending
- div_yumi  out  1  result consumed
- cdb_req  out  1  request CDB for divider result
- cdb_grant  in  1  CDB arbiter grant

Behaviour:
- Reset (async, reset_n=0):
  - All entries invalid; inflight=0; kill_pending=0.
  - Outputs: alloc_ready=1; div_valid_in=0; div_yumi=0; cdb_req=0; div_rob, div_aluop and operands 0.
  - Reset mid-division clears the scheduler only; the divider is reset by the same net.
- Storage is a collapsing queue; slot 0 is the oldest.
  - Entry fields: valid, rob, aluop, s1_rdy/tag/val, s2_rdy/tag/val.
  - When an entry issues, every younger entry shifts down one slot in the same edge.
- Allocate:
  - Occurs when alloc_valid & alloc_ready & ~flush.
  - Writes the first free slot after this cycle's collapse, so issue and alloc in one cycle both succeed even when the queue is full.
  - alloc_ready = (count < DEPTH) | issue_fire. A registered variant is not allowed.
- Wakeup:
  - Condition: cdb_valid and a not-ready source whose tag equals cdb_in.dest_ROB_entry.
  - Action: capture cdb_in.result and set rdy at the next edge.
  - Applies to both sources and to all entries in parallel.
  - Also applies to the allocating entry in the same cycle (alloc-time bypass).
- Issue select:
  - Candidate = lowest slot with valid & s1_rdy & s2_rdy, using registered state only.
  - Wakeup-to-issue latency is 1 cycle.
  - An op allocated with both sources ready is eligible the next cycle.
- Issue fire:
  - Fires when a candidate exists & div_ready & ~inflight & ~flush.
  - Asserts div_valid_in for exactly one cycle, combinationally driving div_rob, div_aluop and the operands from the candidate.
  - The entry is freed at that edge and inflight is set.
  - div_valid_in is never asserted while div_ready=0, because the divider samples its operand registers on valid_in in every state.
- Result path:
  - cdb_req = div_valid_out & ~kill_pending.
  - div_yumi = (cdb_req & cdb_grant) | (div_valid_out & kill_pending).
  - On div_yumi: clear inflight and kill_pending.
  - The divider's CDB packet bypasses this block; only the handshake passes through it.
- Flush:
  - Takes effect at the next edge: all entries are invalidated, and alloc and issue are suppressed that cycle.
  - If inflight=1 (including an op issuing that same cycle, which is suppressed anyway), set kill_pending.
  - The killed result is silently yumi'd when it appears, with no cdb_req.
  - Flush while kill_pending=1 has no further effect.
- Simultaneous div_yumi and issue: not possible, because inflight blocks issue until the cycle after yumi.
- Divide-by-zero: not special-cased here; operands pass through unchanged.

Decomposition:
- Package (structs.svh): CDB_packet_t (existing); new div_rs_entry_t typedef; ROB_W and DIV_RS_DEPTH constants.
- One sub-module, div_rs_pick:
  - Combinational lowest-index ready-entry priority encoder.
  - Outputs: found flag and index.
- The top level holds the queue, collapse/alloc logic, CDB wakeup comparators, and the inflight/kill_pending flags.

Test Plan:
- Ready alloc: alloc rob=3, aluop=1, s1=100, s2=3, both ready; div_ready=1 → div_valid_in one cycle later with dividend=100, divisor=3, rob=3. div_valid_out then cdb_grant → cdb_req high until grant, div_yumi with grant, inflight cleared.
- Wakeup: alloc rob=5, s1 ready=0xFFFFFFFF, s2 tag=7 not ready; then cdb_valid with dest=7, result=10 → issue the following cycle, divisor=10. A CDB with dest=6 causes no wakeup.
- Age order: entries A(rob1, waiting tag 9), B(rob2, ready), C(rob4, ready); wake A → B issues first, then C, then A; queue collapses correctly.
- Full queue: fill 4 entries, alloc_ready=0 → with an issue in the same cycle, alloc_ready=1 and the new op lands in slot 3. No alloc while div_ready=0 is dropped.
- Flush in flight: issue rob=8; flush during division → entries cleared, no cdb_req, div_yumi auto-asserted on div_valid_out. The next alloc issues normally.
- Async reset mid-op: drop reset_n during division → all outputs immediately reach reset values; alloc_ready=1.

Source files
------------

// File: rtl/div_rs_sched_pkg.sv
// rtl/div_rs_sched_pkg.sv - shared types, constants and wakeup helper for the divide reservation station
package div_rs_sched_pkg;
    localparam int ROB_W        = 4;
    localparam int DIV_RS_DEPTH = 4;

    typedef struct packed {
        logic [ROB_W-1:0] dest_ROB_entry;
        logic [31:0]      result;
    } CDB_packet_t;

    typedef struct packed {
        logic             valid;
        logic [ROB_W-1:0] rob;
        logic [3:0]       aluop;
        logic             s1_rdy;
        logic [ROB_W-1:0] s1_tag;
        logic [31:0]      s1_val;
        logic             s2_rdy;
        logic [ROB_W-1:0] s2_tag;
        logic [31:0]      s2_val;
    } div_rs_entry_t;

    // Capture a broadcast result into any waiting source whose producer tag matches.
    function automatic div_rs_entry_t div_rs_wake(div_rs_entry_t e, logic cdb_valid, CDB_packet_t cdb);
        div_rs_entry_t w;
        w = e;
        if (cdb_valid && !e.s1_rdy && (e.s1_tag == cdb.dest_ROB_entry)) begin
            w.s1_rdy = 1'b1;
            w.s1_val = cdb.result;
        end
        if (cdb_valid && !e.s2_rdy && (e.s2_tag == cdb.dest_ROB_entry)) begin
            w.s2_rdy = 1'b1;
            w.s2_val = cdb.result;
        end
        return w;
    endfunction
endpackage

// File: rtl/div_rs_pick.sv
// rtl/div_rs_pick.sv - lowest-index ready-entry priority encoder
module div_rs_pick #(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0]         req,
    output logic                     found,
    output logic [$clog2(DEPTH)-1:0] idx
);
    localparam int IDX_W = $clog2(DEPTH);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end
endmodule

// File: rtl/div_rs_sched.sv
// rtl/div_rs_sched.sv - divide reservation station, oldest-ready issue and result handshake
module div_rs_sched #(
    parameter int DEPTH = div_rs_sched_pkg::DIV_RS_DEPTH,
    parameter int ROB_W = div_rs_sched_pkg::ROB_W
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          alloc_valid,
    output logic                          alloc_ready,
    input  logic [ROB_W-1:0]              alloc_rob,
    input  logic [3:0]                    alloc_aluop,
    input  logic                          alloc_s1_rdy,
    input  logic [ROB_W-1:0]              alloc_s1_tag,
    input  logic [31:0]                   alloc_s1_val,
    input  logic                          alloc_s2_rdy,
    input  logic [ROB_W-1:0]              alloc_s2_tag,
    input  logic [31:0]                   alloc_s2_val,
    input  logic                          cdb_valid,
    input  div_rs_sched_pkg::CDB_packet_t cdb_in,
    input  logic                          flush,
    output logic                          div_valid_in,
    input  logic                          div_ready,
    output logic [ROB_W-1:0]              div_rob,
    output logic [3:0]                    div_aluop,
    output logic [31:0]                   div_dividend,
    output logic [31:0]                   div_divisor,
    input  logic                          div_valid_out,
    output logic                          div_yumi,
    output logic                          cdb_req,
    input  logic                          cdb_grant
);
    import div_rs_sched_pkg::div_rs_entry_t;
    import div_rs_sched_pkg::div_rs_wake;

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    div_rs_entry_t    q     [DEPTH];
    div_rs_entry_t    woke  [DEPTH];
    div_rs_entry_t    q_nxt [DEPTH];
    div_rs_entry_t    cand;
    div_rs_entry_t    new_ent;
    logic             inflight;
    logic             kill_pending;
    logic [DEPTH-1:0] ready_vec;
    logic             found;
    logic [IDX_W-1:0] pick_idx;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] tail;
    logic             issue_fire;
    logic             alloc_fire;

    always_comb begin
        ready_vec = '0;
        count     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ready_vec[i] = q[i].valid & q[i].s1_rdy & q[i].s2_rdy;
            count        = count + CNT_W'(q[i].valid);
        end
    end

    div_rs_pick #(.DEPTH(DEPTH)) u_pick (
        .req   (ready_vec),
        .found (found),
        .idx   (pick_idx)
    );

    assign cand         = q[pick_idx];
    assign issue_fire   = found & div_ready & ~inflight & ~flush;
    assign alloc_ready  = (count < CNT_W'(DEPTH)) | issue_fire;
    assign alloc_fire   = alloc_valid & alloc_ready & ~flush;

    assign div_valid_in = issue_fire;
    assign div_rob      = issue_fire ? cand.rob    : '0;
    assign div_aluop    = issue_fire ? cand.aluop  : '0;
    assign div_dividend = issue_fire ? cand.s1_val : '0;
    assign div_divisor  = issue_fire ? cand.s2_val : '0;

    assign cdb_req      = div_valid_out & ~kill_pending;
    assign div_yumi     = (cdb_req & cdb_grant) | (div_valid_out & kill_pending);

    // The allocating op sees this cycle's broadcast too, so it never misses its producer.
    always_comb begin
        new_ent        = '0;
        new_ent.valid  = 1'b1;
        new_ent.rob    = alloc_rob;
        new_ent.aluop  = alloc_aluop;
        new_ent.s1_rdy = alloc_s1_rdy;
        new_ent.s1_tag = alloc_s1_tag;
        new_ent.s1_val = alloc_s1_val;
        new_ent.s2_rdy = alloc_s2_rdy;
        new_ent.s2_tag = alloc_s2_tag;
        new_ent.s2_val = alloc_s2_val;
        new_ent        = div_rs_wake(new_ent, cdb_valid, cdb_in);
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woke[i] = div_rs_wake(q[i], cdb_valid, cdb_in);
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            q_nxt[i] = (issue_fire && (i >= int'(pick_idx))) ? woke[i + 1] : woke[i];
        end
        q_nxt[DEPTH-1] = issue_fire ? '0 : woke[DEPTH-1];
        // New op lands behind the survivors of this cycle's collapse.
        tail = count - CNT_W'(issue_fire);
        if (alloc_fire) begin
            q_nxt[tail[IDX_W-1:0]] = new_ent;
        end
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_nxt[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= '0;
            end
            inflight     <= 1'b0;
            kill_pending <= 1'b0;
        end else begin
            q <= q_nxt;
            if (div_yumi) begin
                inflight     <= 1'b0;
                kill_pending <= 1'b0;
            end else begin
                if (issue_fire) begin
                    inflight <= 1'b1;
                end
                if (flush && inflight) begin
                    kill_pending <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_div_rs_sched.sv
// tb/tb_div_rs_sched.sv - self-checking bench for div_rs_sched with a queue-based reference model
module tb_div_rs_sched;
    import div_rs_sched_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        alloc_valid = 1'b0;
    logic        alloc_ready;
    logic [3:0]  alloc_rob = '0;
    logic [3:0]  alloc_aluop = '0;
    logic        alloc_s1_rdy = 1'b0;
    logic [3:0]  alloc_s1_tag = '0;
    logic [31:0] alloc_s1_val = '0;
    logic        alloc_s2_rdy = 1'b0;
    logic [3:0]  alloc_s2_tag = '0;
    logic [31:0] alloc_s2_val = '0;
    logic        cdb_valid = 1'b0;
    CDB_packet_t cdb_in = '0;
    logic        flush = 1'b0;
    logic        div_valid_in;
    logic        div_ready = 1'b1;
    logic [3:0]  div_rob;
    logic [3:0]  div_aluop;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic        div_valid_out = 1'b0;
    logic        div_yumi;
    logic        cdb_req;
    logic        cdb_grant = 1'b0;

    div_rs_sched dut (
        .clk(clk), .reset_n(reset_n),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_rob(alloc_rob),
        .alloc_aluop(alloc_aluop), .alloc_s1_rdy(alloc_s1_rdy), .alloc_s1_tag(alloc_s1_tag),
        .alloc_s1_val(alloc_s1_val), .alloc_s2_rdy(alloc_s2_rdy), .alloc_s2_tag(alloc_s2_tag),
        .alloc_s2_val(alloc_s2_val), .cdb_valid(cdb_valid), .cdb_in(cdb_in), .flush(flush),
        .div_valid_in(div_valid_in), .div_ready(div_ready), .div_rob(div_rob),
        .div_aluop(div_aluop), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_valid_out(div_valid_out), .div_yumi(div_yumi), .cdb_req(cdb_req),
        .cdb_grant(cdb_grant)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  rob;
        logic [3:0]  aluop;
        bit          s1_rdy;
        logic [3:0]  s1_tag;
        logic [31:0] s1_val;
        bit          s2_rdy;
        logic [3:0]  s2_tag;
        logic [31:0] s2_val;
    } m_ent_t;

    m_ent_t m_q[$];
    bit     m_inflight = 0, m_kill = 0, m_fired = 0, m_yumied = 0;
    bit     e_found, e_fire, e_alloc_ready, e_cdb_req, e_yumi;
    int     e_idx;
    int     checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected combinational outputs from the model queue and the current inputs.
    function automatic void compute();
        e_found = 0;
        e_idx   = 0;
        for (int i = 0; i < m_q.size(); i++) begin
            if (!e_found && m_q[i].s1_rdy && m_q[i].s2_rdy) begin
                e_found = 1;
                e_idx   = i;
            end
        end
        e_fire        = e_found && div_ready && !m_inflight && !flush;
        e_alloc_ready = (m_q.size() < DEPTH) || e_fire;
        e_cdb_req     = div_valid_out && !m_kill;
        e_yumi        = (e_cdb_req && cdb_grant) || (div_valid_out && m_kill);
    endfunction

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_q.delete();
            m_inflight = 0;
            m_kill     = 0;
            m_fired    = 0;
            m_yumied   = 0;
        end else begin
            m_ent_t n;
            compute();
            if (cdb_valid) begin
                for (int i = 0; i < m_q.size(); i++) begin
                    if (!m_q[i].s1_rdy && m_q[i].s1_tag == cdb_in.dest_ROB_entry) begin
                        m_q[i].s1_rdy = 1;
                        m_q[i].s1_val = cdb_in.result;
                    end
                    if (!m_q[i].s2_rdy && m_q[i].s2_tag == cdb_in.dest_ROB_entry) begin
                        m_q[i].s2_rdy = 1;
                        m_q[i].s2_val = cdb_in.result;
                    end
                end
            end
            if (e_fire) m_q.delete(e_idx);
            if (alloc_valid && e_alloc_ready && !flush) begin
                n = '{alloc_rob, alloc_aluop, alloc_s1_rdy, alloc_s1_tag, alloc_s1_val,
                      alloc_s2_rdy, alloc_s2_tag, alloc_s2_val};
                if (cdb_valid && !n.s1_rdy && n.s1_tag == cdb_in.dest_ROB_entry) begin
                    n.s1_rdy = 1;
                    n.s1_val = cdb_in.result;
                end
                if (cdb_valid && !n.s2_rdy && n.s2_tag == cdb_in.dest_ROB_entry) begin
                    n.s2_rdy = 1;
                    n.s2_val = cdb_in.result;
                end
                m_q.push_back(n);
            end
            if (flush) m_q.delete();
            if (e_yumi) begin
                m_inflight = 0;
                m_kill     = 0;
            end else if (flush && m_inflight) begin
                m_kill = 1;
            end
            if (e_fire) m_inflight = 1;
            m_fired  = e_fire;
            m_yumied = e_yumi;
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            compute();
            chk("alloc_ready", alloc_ready, e_alloc_ready);
            chk("div_valid_in", div_valid_in, e_fire);
            chk("cdb_req", cdb_req, e_cdb_req);
            chk("div_yumi", div_yumi, e_yumi);
            if (e_fire) begin
                chk("div_rob", div_rob, m_q[e_idx].rob);
                chk("div_aluop", div_aluop, m_q[e_idx].aluop);
                chk("div_dividend", div_dividend, m_q[e_idx].s1_val);
                chk("div_divisor", div_divisor, m_q[e_idx].s2_val);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc(input logic [3:0] rob, input logic [3:0] op,
                         input bit r1, input logic [3:0] t1, input logic [31:0] v1,
                         input bit r2, input logic [3:0] t2, input logic [31:0] v2);
        alloc_valid  = 1;
        alloc_rob    = rob;
        alloc_aluop  = op;
        alloc_s1_rdy = r1;
        alloc_s1_tag = t1;
        alloc_s1_val = v1;
        alloc_s2_rdy = r2;
        alloc_s2_tag = t2;
        alloc_s2_val = v2;
    endtask

    task automatic drain();
        div_ready = 0;
        tick();
        div_valid_out = 1;
        cdb_grant     = 1;
        tick();
        div_valid_out = 0;
        cdb_grant     = 0;
        div_ready     = 1;
    endtask

    task automatic chk_issue(input string name, input logic [3:0] rob, input logic [31:0] dvd, input logic [31:0] dvs);
        #1;
        chk({name, "_valid"}, div_valid_in, 1);
        chk({name, "_rob"}, div_rob, rob);
        chk({name, "_dividend"}, div_dividend, dvd);
        chk({name, "_divisor"}, div_divisor, dvs);
    endtask

    bit d_busy = 0, d_valid = 0;
    int d_cnt = 0;

    initial begin
        repeat (2) tick();
        chk("reset_alloc_ready", alloc_ready, 1);
        chk("reset_div_valid_in", div_valid_in, 0);
        chk("reset_div_yumi", div_yumi, 0);
        chk("reset_cdb_req", cdb_req, 0);
        chk("reset_div_rob", div_rob, 0);
        reset_n = 1;
        tick();

        // Ready alloc and result handshake
        alloc(3, 1, 1, 0, 100, 1, 0, 3);
        tick();
        alloc_valid = 0;
        chk_issue("ready_alloc", 3, 100, 3);
        chk("ready_alloc_aluop", div_aluop, 1);
        tick();
        div_ready = 0;
        #1 chk("one_cycle_issue", div_valid_in, 0);
        tick();
        div_valid_out = 1;
        #1 chk("res_cdb_req", cdb_req, 1);
        chk("res_no_yumi", div_yumi, 0);
        tick();
        cdb_grant = 1;
        #1 chk("res_yumi", div_yumi, 1);
        tick();
        div_valid_out = 0;
        cdb_grant     = 0;
        div_ready     = 1;

        // Wakeup from CDB, non-matching tag ignored
        alloc(5, 0, 1, 0, 32'hFFFF_FFFF, 0, 7, 0);
        tick();
        alloc_valid = 0;
        cdb_valid   = 1;
        cdb_in      = '{dest_ROB_entry: 4'd6, result: 32'd99};
        #1 chk("wake_wrong_tag", div_valid_in, 0);
        tick();
        cdb_in = '{dest_ROB_entry: 4'd7, result: 32'd10};
        #1 chk("wake_same_cycle", div_valid_in, 0);
        tick();
        cdb_valid = 0;
        chk_issue("wake", 5, 32'hFFFF_FFFF, 10);
        tick();
        drain();

        // Age order: B then C then A
        div_ready = 0;
        alloc(1, 1, 1, 0, 50, 0, 9, 0);
        tick();
        alloc(2, 1, 1, 0, 20, 1, 0, 2);
        tick();
        alloc(4, 0, 1, 0, 40, 1, 0, 4);
        tick();
        alloc_valid = 0;
        div_ready   = 1;
        chk_issue("age_b", 2, 20, 2);
        tick();
        drain();
        chk_issue("age_c", 4, 40, 4);
        tick();
        cdb_valid = 1;
        cdb_in    = '{dest_ROB_entry: 4'd9, result: 32'd7};
        drain();
        cdb_valid = 0;
        chk_issue("age_a", 1, 50, 7);
        tick();
        drain();

        // Full queue with same-cycle issue and alloc
        div_ready = 0;
        for (int k = 0; k < 4; k++) begin
            alloc(4'(10 + k), 1, 1, 0, 32'(1000 + k), 1, 0, 32'(k + 1));
            tick();
        end
        alloc_valid = 0;
        #1 chk("full_alloc_ready", alloc_ready, 0);
        div_ready = 1;
        alloc(14, 0, 1, 0, 1004, 1, 0, 5);
        #1 chk("full_issue_alloc_ready", alloc_ready, 1);
        chk_issue("full_first", 10, 1000, 1);
        tick();
        alloc_valid = 0;
        for (int k = 11; k <= 14; k++) begin
            drain();
            chk_issue("full_order", 4'(k), 32'(990 + k), 32'(k - 9));
            tick();
        end
        drain();

        // Flush with an op in flight
        alloc(8, 1, 1, 0, 80, 1, 0, 8);
        tick();
        alloc_valid = 0;
        chk_issue("flush_issue", 8, 80, 8);
        tick();
        div_ready = 0;
        alloc(2, 1, 1, 0, 22, 1, 0, 2);
        tick();
        alloc_valid = 0;
        flush       = 1;
        tick();
        flush         = 0;
        div_valid_out = 1;
        #1 chk("flush_no_cdb_req", cdb_req, 0);
        chk("flush_auto_yumi", div_yumi, 1);
        tick();
        div_valid_out = 0;
        div_ready     = 1;
        #1 chk("flush_queue_empty", div_valid_in, 0);
        alloc(6, 0, 1, 0, 66, 1, 0, 6);
        tick();
        alloc_valid = 0;
        chk_issue("after_flush", 6, 66, 6);
        tick();
        drain();

        // Asynchronous reset mid-division
        alloc(9, 1, 1, 0, 90, 1, 0, 9);
        tick();
        alloc(3, 1, 1, 0, 30, 1, 0, 3);
        tick();
        alloc_valid = 0;
        div_ready   = 0;
        #3;
        reset_n   = 0;
        div_ready = 1;
        #1 chk("areset_alloc_ready", alloc_ready, 1);
        chk("areset_div_valid_in", div_valid_in, 0);
        chk("areset_cdb_req", cdb_req, 0);
        chk("areset_div_yumi", div_yumi, 0);
        tick();
        reset_n = 1;
        alloc(12, 1, 1, 0, 120, 1, 0, 12);
        tick();
        alloc_valid = 0;
        chk_issue("after_reset", 12, 120, 12);
        tick();
        drain();

        // Randomized traffic against the model with a simple divider model
        for (int c = 0; c < 3000; c++) begin
            if (m_fired) begin
                d_busy  = 1;
                d_valid = 0;
                d_cnt   = $urandom_range(0, 3);
            end else if (d_valid && m_yumied) begin
                d_busy  = 0;
                d_valid = 0;
            end else if (d_busy && !d_valid) begin
                if (d_cnt == 0) d_valid = 1;
                else d_cnt--;
            end
            div_ready     = !d_busy && ($urandom_range(0, 3) != 0);
            div_valid_out = d_valid;
            cdb_grant     = $urandom_range(0, 1);
            alloc($urandom_range(0, 15), $urandom_range(0, 15),
                  $urandom_range(0, 1), $urandom_range(0, 7), $urandom,
                  $urandom_range(0, 1), $urandom_range(0, 7), $urandom);
            alloc_valid = ($urandom_range(0, 9) < 6);
            cdb_valid   = $urandom_range(0, 1);
            cdb_in      = '{dest_ROB_entry: 4'($urandom_range(0, 7)), result: $urandom};
            flush       = ($urandom_range(0, 24) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
